mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between the instruction-fetch requester (IF) and the load/store requester (D).
- Arbitrates between the two, then drives the memory address/data/control through registered-select 2:1 muxes.
- Sequences each request/response transaction and routes the memory response back to the requester that owns it.
- Only one transaction is ever outstanding; D has priority, with an anti-starvation guard for IF.

---
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory bus bundle for mem_port_arbiter
//
// Carries the fetch (if_*), load/store (d_*) and memory (mem_*) handshakes.
//   slave  : arbiter view (takes requests and memory responses, drives gnt/rvalid and mem_*)
//   master : environment view (requesters and memory model)
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic              if_req;
  logic [AW-1:0]     if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DW-1:0]     if_rdata;

  logic              d_req;
  logic              d_we;
  logic [DW/8-1:0]   d_be;
  logic [AW-1:0]     d_addr;
  logic [DW-1:0]     d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DW-1:0]     d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [DW/8-1:0]   mem_be;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DW-1:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_be, d_addr, d_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and load/store
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.slave (if_*, d_*, mem_* handshakes)
//   owner  : registered owner of the current/last transaction (0 = IF, 1 = D)
//   busy   : high whenever a transaction is in flight
//   err    : one-cycle response-timeout pulse (only with MEM_ARB_TIMEOUT_EN, else 0)
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to build the WAIT watchdog
// (TIMEOUT cycles without mem_rvalid completes the transaction with rdata = 0).
module mem_port_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT        = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mem_port_arbiter_if.slave       bus,
  output logic                    owner,
  output logic                    busy,
  output logic                    err
);

  if (MAX_DATA_BURST < 1 || MAX_DATA_BURST > 255 || TIMEOUT < 1 || (DW % 8) != 0) begin : g_param_check
    $error("mem_port_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [7:0] MAX_BURST = 8'(MAX_DATA_BURST);

  state_t      state_q, state_d;
  logic        owner_d;
  logic [7:0]  starve_q, starve_d;
  logic        d_wins;
  logic        timeout;
  logic        rsp_done;
  logic [DW-1:0] rsp_data;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int            CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  logic [CW-1:0] wait_cnt_q;

  // Held at zero outside WAIT, so it is already clear on the first WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (state_q != WAIT) begin
      wait_cnt_q <= '0;
    end else if (wait_cnt_q != TIMEOUT_C) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q == WAIT) && !bus.mem_rvalid && (wait_cnt_q == TIMEOUT_C);
  assign err     = timeout;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // D wins unless IF is waiting and D has already had MAX_DATA_BURST grants in a row.
  assign d_wins   = bus.d_req && (!bus.if_req || (starve_q < MAX_BURST));
  assign rsp_done = (state_q == WAIT) && (bus.mem_rvalid || timeout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner    <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner    <= owner_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          owner_d = d_wins;
          state_d = REQ;
        end
        // d_wins with if_req high implies starve_q < MAX_BURST, so this never overflows.
        if (d_wins && bus.if_req) begin
          starve_d = starve_q + 8'd1;
        end else begin
          starve_d = '0;
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (rsp_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address/control muxes select on the registered owner only; fetches are
  // always full-width reads.
  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_addr  = owner ? bus.d_addr  : bus.if_addr;
  assign bus.mem_we    = owner & bus.d_we;
  assign bus.mem_be    = owner ? bus.d_be    : '1;
  assign bus.mem_wdata = owner ? bus.d_wdata : '0;

  assign bus.if_gnt    = (state_q == REQ) && bus.mem_gnt && !owner;
  assign bus.d_gnt     = (state_q == REQ) && bus.mem_gnt &&  owner;

  // Responses outside WAIT never reach a requester.
  assign rsp_data      = timeout ? '0 : bus.mem_rdata;
  assign bus.if_rvalid = rsp_done && !owner;
  assign bus.d_rvalid  = rsp_done &&  owner;
  assign bus.if_rdata  = bus.if_rvalid ? rsp_data : '0;
  assign bus.d_rdata   = bus.d_rvalid  ? rsp_data : '0;

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXB = 4;
  localparam int TO   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic owner, busy, err;
  int   errors = 0;
  int   checks = 0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DATA_BURST(MAXB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .owner(owner), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit            is_d;
    bit            we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            gnt_delay;
    int            rsp_delay;
    bit            exp_owner;
    bit            exp_we;
    logic [BW-1:0] exp_be;
    logic [DW-1:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    bit            we;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } txn_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(bit is_d, bit we, logic [BW-1:0] be, logic [AW-1:0] addr,
                               logic [DW-1:0] wdata, logic [DW-1:0] rdata, int gd, int rd,
                               bit eo, bit ewe, logic [BW-1:0] ebe, logic [DW-1:0] ewd);
    vec_t v;
    v.is_d = is_d; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.gnt_delay = gd; v.rsp_delay = rd;
    v.exp_owner = eo; v.exp_we = ewe; v.exp_be = ebe; v.exp_wdata = ewd;
    return v;
  endfunction

  task automatic clear_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.is_d) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_be = v.be; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
      bus.d_we = 1'b1; bus.d_be = 4'h1; bus.d_addr = 32'h0BAD0BAD; bus.d_wdata = 32'hDEADBEEF;
    end
    @(negedge clk);
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " idle mem_req"}, bus.mem_req, 0);
    next_cycle();
    for (int k = 0; k < v.gnt_delay; k++) begin
      bus.mem_gnt = 1'b0;
      @(negedge clk);
      chk({tag, " stall mem_req"}, bus.mem_req, 1);
      chk({tag, " stall mem_addr"}, bus.mem_addr, v.addr);
      chk({tag, " stall gnt"}, {bus.if_gnt, bus.d_gnt}, 2'b00);
      next_cycle();
    end
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    chk({tag, " mem_req"}, bus.mem_req, 1);
    chk({tag, " mem_addr"}, bus.mem_addr, v.addr);
    chk({tag, " mem_we"}, bus.mem_we, v.exp_we);
    chk({tag, " mem_be"}, bus.mem_be, v.exp_be);
    chk({tag, " mem_wdata"}, bus.mem_wdata, v.exp_wdata);
    chk({tag, " owner"}, owner, v.exp_owner);
    chk({tag, " gnt {if,d}"}, {bus.if_gnt, bus.d_gnt}, v.is_d ? 2'b01 : 2'b10);
    next_cycle();
    bus.mem_gnt = 1'b0; bus.if_req = 1'b0; bus.d_req = 1'b0;
    for (int k = 0; k < v.rsp_delay; k++) begin
      @(negedge clk);
      chk({tag, " wait mem_req"}, bus.mem_req, 0);
      chk({tag, " wait busy"}, busy, 1);
      chk({tag, " wait rvalid"}, {bus.if_rvalid, bus.d_rvalid}, 2'b00);
      next_cycle();
    end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = v.rdata;
    @(negedge clk);
    chk({tag, " rvalid {if,d}"}, {bus.if_rvalid, bus.d_rvalid}, v.is_d ? 2'b01 : 2'b10);
    chk({tag, " rdata"}, v.is_d ? bus.d_rdata : bus.if_rdata, v.rdata);
    chk({tag, " err"}, err, 0);
    next_cycle();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk({tag, " done busy"}, busy, 0);
    next_cycle();
  endtask

  initial begin
    int   found;
    bit   exp_own[10];
    int   mphase, wait_n, mstarve;
    bit   mowner, if_pend, d_pend, dwin;
    txn_t cur;

    vecs[0] = mkv(0, 0, 4'h0, 32'h0000_0100, 32'h0, 32'h0050_0093, 0, 0, 0, 0, 4'hF, 32'h0);
    vecs[1] = mkv(1, 1, 4'hF, 32'h0000_2000, 32'hCAFE_F00D, 32'h0, 0, 1, 1, 1, 4'hF, 32'hCAFE_F00D);
    vecs[2] = mkv(1, 0, 4'h3, 32'h0000_3004, 32'h55AA_55AA, 32'h1234_5678, 2, 0, 1, 0, 4'h3, 32'h55AA_55AA);
    vecs[3] = mkv(0, 0, 4'h0, 32'h0000_0104, 32'h0, 32'h0000_0013, 5, 2, 0, 0, 4'hF, 32'h0);
    vecs[4] = mkv(1, 1, 4'h8, 32'hFFFF_FFFC, 32'hA500_0000, 32'h0, 1, 3, 1, 1, 4'h8, 32'hA500_0000);
    vecs[5] = mkv(0, 0, 4'h0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 0, 0, 0, 0, 4'hF, 32'h0);

    clear_inputs();
    rst_n = 1'b0;
    #3;
    chk("reset busy", busy, 0);
    chk("reset owner", owner, 0);
    chk("reset mem_req", bus.mem_req, 0);
    chk("reset gnt/rvalid", {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid}, 4'b0000);
    chk("reset mem_be follows IF", bus.mem_be, 4'hF);
    chk("reset err", err, 0);
    do_reset();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Simultaneous requests from reset: D first, then IF.
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0400;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF; bus.d_addr = 32'h0000_2000; bus.d_wdata = 32'hCAFE_F00D;
    next_cycle();
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    chk("simul first owner", owner, 1);
    chk("simul first addr", bus.mem_addr, 32'h0000_2000);
    chk("simul first we", bus.mem_we, 1);
    chk("simul first wdata", bus.mem_wdata, 32'hCAFE_F00D);
    chk("simul first gnt {if,d}", {bus.if_gnt, bus.d_gnt}, 2'b01);
    next_cycle();
    bus.d_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0;
    @(negedge clk);
    chk("simul first rvalid {if,d}", {bus.if_rvalid, bus.d_rvalid}, 2'b01);
    next_cycle();
    bus.mem_rvalid = 1'b0;
    next_cycle();
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    chk("simul second owner", owner, 0);
    chk("simul second addr", bus.mem_addr, 32'h0000_0400);
    chk("simul second we", bus.mem_we, 0);
    chk("simul second gnt {if,d}", {bus.if_gnt, bus.d_gnt}, 2'b10);
    next_cycle();
    bus.if_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0013;
    @(negedge clk);
    chk("simul second rvalid {if,d}", {bus.if_rvalid, bus.d_rvalid}, 2'b10);
    chk("simul second rdata", bus.if_rdata, 32'h0000_0013);
    next_cycle();
    bus.mem_rvalid = 1'b0;

    // Starvation guard: both requesters permanently asking.
    exp_own = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0800;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h0000_4000;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk($sformatf("starve%0d idle busy", t), busy, 0);
      next_cycle();
      bus.mem_gnt = 1'b1;
      @(negedge clk);
      chk($sformatf("starve%0d owner", t), owner, exp_own[t]);
      chk($sformatf("starve%0d gnt {if,d}", t), {bus.if_gnt, bus.d_gnt}, exp_own[t] ? 2'b01 : 2'b10);
      next_cycle();
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1;
      next_cycle();
      bus.mem_rvalid = 1'b0;
    end
    clear_inputs();

    // Reset while waiting for a D response.
    do_reset();
    bus.d_req = 1'b1; bus.d_addr = 32'h0000_5000; bus.d_be = 4'hF;
    next_cycle();
    bus.mem_gnt = 1'b1;
    next_cycle();
    bus.mem_gnt = 1'b0; bus.d_req = 1'b0;
    @(negedge clk);
    chk("rstwait pre busy", busy, 1);
    chk("rstwait pre owner", owner, 1);
    rst_n = 1'b0;
    #1;
    chk("rstwait busy", busy, 0);
    chk("rstwait owner", owner, 0);
    chk("rstwait mem_req", bus.mem_req, 0);
    next_cycle();
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("rstwait late rvalid {if,d}", {bus.if_rvalid, bus.d_rvalid}, 2'b00);
    chk("rstwait late busy", busy, 0);
    next_cycle();
    bus.mem_rvalid = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
    do_reset();
    bus.d_req = 1'b1; bus.d_addr = 32'h0000_6000; bus.d_be = 4'hF;
    next_cycle();
    bus.mem_gnt = 1'b1;
    next_cycle();
    bus.mem_gnt = 1'b0; bus.d_req = 1'b0; bus.mem_rdata = 32'h1111_1111;
    found = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bus.d_rvalid || err) begin
        found = k;
        chk("timeout err", err, 1);
        chk("timeout d_rvalid", bus.d_rvalid, 1);
        chk("timeout d_rdata", bus.d_rdata, 0);
        chk("timeout if_rvalid", bus.if_rvalid, 0);
        break;
      end
      next_cycle();
    end
    chk("timeout wait cycles", found, TO);
    next_cycle();
    @(negedge clk);
    chk("timeout busy", busy, 0);
    chk("timeout err pulse", err, 0);
    next_cycle();
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    chk("timeout late rvalid {if,d}", {bus.if_rvalid, bus.d_rvalid}, 2'b00);
    next_cycle();
    bus.mem_rvalid = 1'b0;
`endif

    // Randomized traffic against a transaction-level model.
    do_reset();
    mphase = 0; wait_n = 0; mstarve = 0; mowner = 0; if_pend = 0; d_pend = 0;
    cur = '{addr: '0, we: 1'b0, be: '0, wdata: '0};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; bus.if_addr = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; bus.d_we = 1'($urandom); bus.d_be = 4'($urandom);
        bus.d_addr = $urandom; bus.d_wdata = $urandom;
      end
      bus.if_req = if_pend; bus.d_req = d_pend;
      bus.mem_gnt = 1'($urandom);
      if (mphase == 2) bus.mem_rvalid = (wait_n >= 5) || ($urandom_range(0, 2) == 0);
      else             bus.mem_rvalid = ($urandom_range(0, 7) == 0);
      bus.mem_rdata = $urandom;
      @(negedge clk);
      chk("rnd busy", busy, mphase != 0);
      chk("rnd mem_req", bus.mem_req, mphase == 1);
      chk("rnd owner", owner, mowner);
      chk("rnd err", err, 0);
      if (mphase == 1)
        chk("rnd mem bus", {bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata},
            {cur.addr, cur.we, cur.be, cur.wdata});
      chk("rnd gnt {if,d}", {bus.if_gnt, bus.d_gnt},
          {mphase == 1 && bus.mem_gnt && !mowner, mphase == 1 && bus.mem_gnt && mowner});
      chk("rnd rvalid {if,d}", {bus.if_rvalid, bus.d_rvalid},
          {mphase == 2 && bus.mem_rvalid && !mowner, mphase == 2 && bus.mem_rvalid && mowner});
      if (mphase == 2 && bus.mem_rvalid)
        chk("rnd rdata", mowner ? bus.d_rdata : bus.if_rdata, bus.mem_rdata);
      case (mphase)
        0: begin
          dwin = d_pend && (!if_pend || mstarve < MAXB);
          if (if_pend || d_pend) begin
            mowner = dwin;
            if (dwin) cur = '{addr: bus.d_addr, we: bus.d_we, be: bus.d_be, wdata: bus.d_wdata};
            else      cur = '{addr: bus.if_addr, we: 1'b0, be: 4'hF, wdata: 32'h0};
            mphase = 1;
          end
          if (dwin && if_pend) mstarve = (mstarve < MAXB) ? mstarve + 1 : MAXB;
          else                 mstarve = 0;
        end
        1: if (bus.mem_gnt) begin
          mphase = 2; wait_n = 0;
          if (mowner) d_pend = 0; else if_pend = 0;
        end
        default: if (bus.mem_rvalid) mphase = 0; else wait_n++;
      endcase
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
